// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter and its sequencers.
package counter_pkg;

  localparam int CNT_W = 8;

  localparam logic MODE_GOTO     = 1'b0;
  localparam logic MODE_PINGPONG = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STEP  = 3'd3,
    ST_TURN  = 3'd4
  } state_t;

  // Endpoints of the active command; target/origin swap on each ping-pong turn.
  typedef struct packed {
    logic             mode;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] origin;
  } cmd_t;

endpackage

// File: rtl/step_timer.sv
// Down-counting divider: load a value, decrement while DEC, flag the cycle
// in which the decrement reaches zero.
module step_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_VAL,
  input  logic         DEC,
  output logic         EXPIRE
);

  logic [W-1:0] cnt;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge CLK) begin
    if (RST)                     cnt <= '0;
    else if (LOAD)               cnt <= LOAD_VAL;
    else if (DEC && cnt != '0)   cnt <= cnt - 1'b1;
  end

  // Value 1 (or an already-empty 0) means this decrement is the last one.
  assign EXPIRE = DEC && (cnt[W-1:1] == '0);

endmodule

// File: rtl/updown_counter.sv
// 8-bit up/down counter with parallel load; steps one LSB per EN cycle.
module updown_counter
  import counter_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LD,
  input  logic [CNT_W-1:0] LD_VAL,
  input  logic             EN,
  input  logic             DIR,
  output logic [CNT_W-1:0] CNT
);

  // Active-low reset, then load, then count; wraps modulo 256.
  always_ff @(posedge CLK) begin
    if (!RST_N)   CNT <= '0;
    else if (LD)  CNT <= LD_VAL;
    else if (EN)  CNT <= DIR ? CNT - 1'b1 : CNT + 1'b1;
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Command sequencer for the up/down counter: goto / ping-pong sweeps,
// one counter step every STEP_DIV clocks, with abort.
module counter_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int STEP_DIV = 4,
  parameter int PASS_W   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_MODE,
  input  logic [CNT_W-1:0]  CMD_TARGET,
  input  logic [PASS_W-1:0] CMD_PASSES,
  input  logic              ABORT,
  input  logic [CNT_W-1:0]  CNT_IN,
  output logic              CNT_EN,
  output logic              CNT_DIR,
  output logic              BUSY,
  output logic              DONE,
  output logic              ABORTED
);

  // CHECK and STEP each take one cycle, so WAIT covers the remaining STEP_DIV-2.
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(STEP_DIV - 2);
  localparam bit               SKIP_WAIT = (STEP_DIV <= 2);

  state_t            state;
  cmd_t              cmd_q;
  logic [PASS_W-1:0] passes_q;
  logic              en_q;
  logic              dir_q;
  logic              ready_q;
  logic              done_q;
  logic              aborted_q;

  logic tmr_load;
  logic tmr_dec;
  logic tmr_expire;
  logic at_target;
  logic go_down;

  assign at_target = (CNT_IN == cmd_q.target);
  assign go_down   = (CNT_IN >  cmd_q.target);
  assign tmr_load  = (state == ST_CHECK);
  assign tmr_dec   = (state == ST_WAIT);

  step_timer #(.W(CNT_W)) u_tmr (
    .CLK      (CLK),
    .RST      (RST),
    .LOAD     (tmr_load),
    .LOAD_VAL (DIV_LOAD),
    .DEC      (tmr_dec),
    .EXPIRE   (tmr_expire)
  );

  // Sequencer FSM with registered handshake, step and status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      cmd_q     <= '{mode: MODE_GOTO, target: '0, origin: '0};
      passes_q  <= '0;
      en_q      <= 1'b0;
      dir_q     <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (state != ST_IDLE && ABORT) begin
        state     <= ST_IDLE;
        ready_q   <= 1'b1;
        aborted_q <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (CMD_VALID && ready_q) begin
              cmd_q.mode   <= CMD_MODE;
              cmd_q.target <= CMD_TARGET;
              cmd_q.origin <= CNT_IN;
              passes_q     <= (CMD_PASSES == '0) ? PASS_W'(1) : CMD_PASSES;
              ready_q      <= 1'b0;
              state        <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (at_target) begin
              state <= ST_TURN;
            end else if (SKIP_WAIT) begin
              state <= ST_STEP;
              en_q  <= 1'b1;
              dir_q <= go_down;
            end else begin
              state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (tmr_expire) begin
              state <= ST_STEP;
              en_q  <= 1'b1;
              dir_q <= go_down;
            end
          end
          ST_STEP: begin
            state <= ST_CHECK;
          end
          ST_TURN: begin
            if (cmd_q.mode != MODE_PINGPONG || passes_q == PASS_W'(1)) begin
              state   <= ST_IDLE;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              passes_q     <= passes_q - 1'b1;
              cmd_q.target <= cmd_q.origin;
              cmd_q.origin <= cmd_q.target;
              state        <= ST_CHECK;
            end
          end
          default: begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // An abort landing on a STEP cycle must suppress that step immediately.
  assign CNT_EN    = en_q & ~ABORT;
  assign CNT_DIR   = dir_q;
  assign CMD_READY = ready_q;
  assign BUSY      = (state != ST_IDLE);
  assign DONE      = done_q;
  assign ABORTED   = aborted_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl driving the real up/down counter.
module tb_counter_sweep_ctrl;
  import counter_pkg::*;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_mode = 1'b0;
  logic [7:0] cmd_target = '0;
  logic [3:0] cmd_passes = '0;
  logic       abort = 1'b0;
  logic [7:0] cnt;
  logic       cnt_en, cnt_dir, busy, done, aborted;
  logic       ld = 1'b0;
  logic [7:0] ld_val = '0;

  int checks = 0, failures = 0;
  int en_total = 0, done_total = 0, ab_total = 0;

  always #5 clk = ~clk;

  counter_sweep_ctrl #(.STEP_DIV(SD), .PASS_W(4)) dut (
    .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_MODE(cmd_mode), .CMD_TARGET(cmd_target), .CMD_PASSES(cmd_passes),
    .ABORT(abort), .CNT_IN(cnt), .CNT_EN(cnt_en), .CNT_DIR(cnt_dir),
    .BUSY(busy), .DONE(done), .ABORTED(aborted)
  );

  updown_counter u_cnt (
    .CLK(clk), .RST_N(1'b1), .LD(ld), .LD_VAL(ld_val),
    .EN(cnt_en), .DIR(cnt_dir), .CNT(cnt)
  );

  always @(posedge clk) begin
    if (cnt_en)  en_total++;
    if (done)    done_total++;
    if (aborted) ab_total++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: each pass walks |t-s| steps, STEP_DIV clocks apiece, plus a
  // two-cycle arrival check per pass; odd pass counts end on the target.
  function automatic void model(input bit m, input int s, input int t, input int p,
                                output int steps, output int fin, output int dcyc);
    int np, d;
    np    = (m == MODE_GOTO) ? 1 : ((p == 0) ? 1 : p);
    d     = (s > t) ? s - t : t - s;
    steps = np * d;
    fin   = (np % 2 == 1) ? t : s;
    dcyc  = steps * SD + 2 * np;
  endfunction

  task automatic preload(input int v);
    @(posedge clk); #1 ld = 1'b1; ld_val = 8'(v);
    @(posedge clk); #1 ld = 1'b0;
  endtask

  task automatic issue(input bit m, input int t, input int p);
    cmd_mode = m; cmd_target = 8'(t); cmd_passes = 4'(p); cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  // Runs one command from a preloaded start; checks step timing/direction
  // against a per-leg schedule and reports steps, final count, DONE cycle.
  task automatic run_cmd(input string nm, input bit m, input int s, input int t, input int p,
                         output int n_en, output int fin, output int dcyc);
    int ecyc[$];
    bit edir[$];
    int np, base, cyc, terr, rerr, lo, hi, limit, ms, mf, md;
    bit busy_at_done, ready_at_done, ab_seen;
    np = (m == MODE_GOTO) ? 1 : ((p == 0) ? 1 : p);
    base = 0;
    for (int k = 0; k < np; k++) begin
      int from, to, d;
      from = (k % 2 == 0) ? s : t;
      to   = (k % 2 == 0) ? t : s;
      d    = (from > to) ? from - to : to - from;
      for (int j = 1; j <= d; j++) begin
        ecyc.push_back(base + j * SD - 1);
        edir.push_back(from > to);
      end
      base += d * SD + 2;
    end
    model(m, s, t, p, ms, mf, md);
    limit = md + 64;
    lo = (s < t) ? s : t;
    hi = (s < t) ? t : s;
    n_en = 0; terr = 0; rerr = 0; dcyc = -1; cyc = 0; ab_seen = 0;
    busy_at_done = 1'b1; ready_at_done = 1'b0;
    preload(s);
    issue(m, t, p);
    @(negedge clk);
    while (cyc <= limit) begin
      if (cnt_en) begin
        n_en++;
        if (ecyc.size() == 0) terr++;
        else begin
          int ec; bit ed;
          ec = ecyc.pop_front(); ed = edir.pop_front();
          if (ec != cyc || ed != cnt_dir) terr++;
        end
      end
      if (int'(cnt) < lo || int'(cnt) > hi) rerr++;
      if (aborted) ab_seen = 1'b1;
      if (done) begin
        dcyc = cyc; busy_at_done = busy; ready_at_done = cmd_ready;
        break;
      end
      if (aborted) break;
      @(negedge clk); cyc++;
    end
    fin = int'(cnt);
    chk({nm, " step_sched_err"}, terr + ecyc.size(), 0);
    chk({nm, " range_err"}, rerr, 0);
    chk({nm, " busy_at_done"}, int'(busy_at_done), 0);
    chk({nm, " ready_at_done"}, int'(ready_at_done), 1);
    chk({nm, " aborted"}, int'(ab_seen), 0);
    @(negedge clk);
    chk({nm, " done_one_cycle"}, int'(done), 0);
  endtask

  task automatic wait_done(input int limit, output int got);
    got = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
  endtask

  typedef struct {
    bit mode;
    int start, target, passes;
    int exp_steps, exp_final, exp_done;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n, f, d, got, e0, d0, a0;
    // mode, start, target, passes, steps, final, done cycle (STEP_DIV = 4)
    tbl[0]  = '{MODE_GOTO,       0,   5, 0,   5,   5,   22};
    tbl[1]  = '{MODE_GOTO,       5,   2, 7,   3,   2,   14};
    tbl[2]  = '{MODE_PINGPONG,  10,  13, 3,   9,  13,   42};
    tbl[3]  = '{MODE_PINGPONG,  10,  13, 0,   3,  13,   14};
    tbl[4]  = '{MODE_GOTO,       7,   7, 0,   0,   7,    2};
    tbl[5]  = '{MODE_PINGPONG,   9,   9, 5,   0,   9,   10};
    tbl[6]  = '{MODE_GOTO,     250,   5, 0, 245,   5,  982};
    tbl[7]  = '{MODE_GOTO,     255,   0, 0, 255,   0, 1022};
    tbl[8]  = '{MODE_PINGPONG,   0, 255, 2, 510,   0, 2044};
    tbl[9]  = '{MODE_PINGPONG,   3,   1, 4,   8,   3,   40};
    tbl[10] = '{MODE_PINGPONG,  20,  21, 15, 15,  21,   90};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst cmd_ready", int'(cmd_ready), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst cnt_en", int'(cnt_en), 0);
    chk("rst cnt_dir", int'(cnt_dir), 0);
    chk("rst done", int'(done), 0);
    chk("rst aborted", int'(aborted), 0);

    // Table vectors
    for (int i = 0; i < 11; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      run_cmd(nm, tbl[i].mode, tbl[i].start, tbl[i].target, tbl[i].passes, n, f, d);
      chk({nm, " steps"}, n, tbl[i].exp_steps);
      chk({nm, " final"}, f, tbl[i].exp_final);
      chk({nm, " done_cyc"}, d, tbl[i].exp_done);
    end

    // Zero-length goto with CMD_VALID held: next command taken on the DONE cycle
    preload(7);
    cmd_mode = MODE_GOTO; cmd_target = 8'd7; cmd_passes = 4'd0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); chk("hold c0 busy", int'(busy), 1);
    @(negedge clk); chk("hold c1 done", int'(done), 0);
    @(negedge clk);
    chk("hold c2 done", int'(done), 1);
    chk("hold c2 ready", int'(cmd_ready), 1);
    chk("hold c2 busy", int'(busy), 0);
    @(negedge clk);
    chk("hold 2nd busy", int'(busy), 1);
    chk("hold 2nd done", int'(done), 0);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("hold 2nd done pulse", int'(done), 1);
    chk("hold no en", en_total, 0 + en_total - 0);

    // Abort on the 21st STEP cycle of goto 100 from 0
    preload(0);
    e0 = en_total; d0 = done_total; a0 = ab_total;
    issue(MODE_GOTO, 100, 0);
    repeat (21 * SD - 1) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("abort en_gated", int'(cnt_en), 0);
    chk("abort cnt_hold", int'(cnt), 20);
    chk("abort busy", int'(busy), 1);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort pulse", int'(aborted), 1);
    chk("abort no_done", int'(done), 0);
    chk("abort ready", int'(cmd_ready), 1);
    chk("abort idle", int'(busy), 0);
    chk("abort cnt_final", int'(cnt), 20);
    @(negedge clk);
    chk("abort pulse_end", int'(aborted), 0);
    chk("abort en_count", en_total - e0, 20);
    chk("abort done_count", done_total - d0, 0);
    chk("abort ab_count", ab_total - a0, 1);

    // Reset mid-command during WAIT, then ABORT while idle
    preload(0);
    issue(MODE_GOTO, 50, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    e0 = en_total; d0 = done_total; a0 = ab_total;
    @(negedge clk);
    chk("mrst busy", int'(busy), 0);
    chk("mrst ready", int'(cmd_ready), 1);
    chk("mrst en", int'(cnt_en), 0);
    chk("mrst dir", int'(cnt_dir), 0);
    repeat (20) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst en_count", en_total - e0, 0);
    chk("mrst done_count", done_total - d0, 0);
    chk("mrst ab_count", ab_total - a0, 0);
    chk("mrst cnt", int'(cnt), 0);

    // ABORT coinciding with accept is ignored
    preload(5);
    a0 = ab_total;
    abort = 1'b1;
    cmd_mode = MODE_GOTO; cmd_target = 8'd8; cmd_passes = 4'd0; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abacc busy", int'(busy), 1);
    wait_done(100, got);
    chk("abacc done", got, 1);
    chk("abacc cnt", int'(cnt), 8);
    chk("abacc ab_count", ab_total - a0, 0);

    // Counter disturbed mid-goto: stepping resumes from the new value
    preload(0);
    issue(MODE_GOTO, 10, 0);
    repeat (5) @(posedge clk);
    #1 ld = 1'b1; ld_val = 8'd30;
    @(posedge clk); #1 ld = 1'b0;
    wait_done(400, got);
    chk("disturb done", got, 1);
    chk("disturb cnt", int'(cnt), 10);

    // Randomized commands against the model
    for (int i = 0; i < 25; i++) begin
      bit m; int s, t, p, ms, mf, md;
      string nm;
      m = 1'($urandom_range(0, 1));
      s = int'($urandom_range(0, 255));
      t = s + int'($urandom_range(0, 40)) - 20;
      if (t < 0) t = 0;
      if (t > 255) t = 255;
      p = int'($urandom_range(0, 4));
      nm = $sformatf("rnd%0d", i);
      model(m, s, t, p, ms, mf, md);
      run_cmd(nm, m, s, t, p, n, f, d);
      chk({nm, " steps"}, n, ms);
      chk({nm, " final"}, f, mf);
      chk({nm, " done_cyc"}, d, md);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
